// File: rtl/fft_pkg.sv
// fft_pkg: shared widths, sample/twiddle types and output saturation for the FFT butterfly
package fft_pkg;
  localparam int DATA_W = 8;
  localparam int TW_W = 8;
  localparam int ADDR_W = 3;
  localparam int P_W = DATA_W + 2;
  localparam int S_W = DATA_W + 3;
  localparam int M_W = DATA_W + TW_W;
  typedef logic signed [DATA_W-1:0] data_t;
  typedef logic signed [TW_W-1:0] tw_t;
  typedef struct packed {
    data_t re;
    data_t im;
  } cplx_t;
  function automatic logic [DATA_W:0] sat_data(input logic signed [S_W-1:0] v);
    logic signed [S_W-1:0] mx, mn;
    mx = {{(S_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    mn = ~mx;
    return v > mx ? {1'b1, mx[DATA_W-1:0]} : v < mn ? {1'b1, mn[DATA_W-1:0]} : {1'b0, v[DATA_W-1:0]};
  endfunction
endpackage

// File: rtl/bfly_cmul.sv
// bfly_cmul: two-register complex multiply B*W, products then floor-scaled sums
module bfly_cmul
  import fft_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  cplx_t b,
  input  tw_t w_re,
  input  tw_t w_im,
  output logic signed [P_W-1:0] p_re,
  output logic signed [P_W-1:0] p_im
);
  logic signed [M_W-1:0] rr, ii, ri, ir;
  logic signed [M_W:0] sr, si;
  assign sr = (M_W+1)'(rr) - (M_W+1)'(ii);
  assign si = (M_W+1)'(ri) + (M_W+1)'(ir);
  always_ff @(posedge clk)
    if (!rst_n) begin
      rr <= '0;
      ii <= '0;
      ri <= '0;
      ir <= '0;
      p_re <= '0;
      p_im <= '0;
    end else if (en) begin
      rr <= M_W'(b.re) * M_W'(w_re);
      ii <= M_W'(b.im) * M_W'(w_im);
      ri <= M_W'(b.re) * M_W'(w_im);
      ir <= M_W'(b.im) * M_W'(w_re);
      p_re <= P_W'(sr >>> (TW_W - 1));
      p_im <= P_W'(si >>> (TW_W - 1));
    end
endmodule

// File: rtl/fft_butterfly.sv
// fft_butterfly: radix-2 DIT butterfly behind a 1-cycle twiddle ROM; BFLY_ROUND_EN selects round-half-up final halving
module fft_butterfly
  import fft_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  output logic in_ready,
  input  logic signed [DATA_W-1:0] in_a_re,
  input  logic signed [DATA_W-1:0] in_a_im,
  input  logic signed [DATA_W-1:0] in_b_re,
  input  logic signed [DATA_W-1:0] in_b_im,
  input  logic [ADDR_W-1:0] in_tw_idx,
  output logic [ADDR_W-1:0] tw_addr,
  input  logic signed [TW_W-1:0] tw_re,
  input  logic signed [TW_W-1:0] tw_im,
  output logic out_valid,
  input  logic out_ready,
  output logic signed [DATA_W-1:0] out_x_re,
  output logic signed [DATA_W-1:0] out_x_im,
  output logic signed [DATA_W-1:0] out_y_re,
  output logic signed [DATA_W-1:0] out_y_im,
  output logic out_sat
);
  logic adv, accept, v1, v2, v3;
  logic [ADDR_W-1:0] tw_addr_q;
  cplx_t a1, b1, a2, a3;
  logic signed [P_W-1:0] p_re, p_im;
  logic [DATA_W:0] xr, xi, yr, yi;
  function automatic logic signed [S_W-1:0] half(input logic signed [S_W-1:0] v);
`ifdef BFLY_ROUND_EN
    return (v + $signed({{(S_W-1){1'b0}}, 1'b1})) >>> 1;
`else
    return v >>> 1;
`endif
  endfunction
  assign adv = ~out_valid | out_ready;
  assign in_ready = adv;
  assign accept = in_valid & adv;
  assign tw_addr = accept ? in_tw_idx : tw_addr_q;
  assign xr = sat_data(half(S_W'(a3.re) + S_W'(p_re)));
  assign xi = sat_data(half(S_W'(a3.im) + S_W'(p_im)));
  assign yr = sat_data(half(S_W'(a3.re) - S_W'(p_re)));
  assign yi = sat_data(half(S_W'(a3.im) - S_W'(p_im)));
  bfly_cmul u_cmul (
    .clk(clk),
    .rst_n(rst_n),
    .en(adv),
    .b(b1),
    .w_re(tw_re),
    .w_im(tw_im),
    .p_re(p_re),
    .p_im(p_im)
  );
  always_ff @(posedge clk)
    if (!rst_n) begin
      tw_addr_q <= '0;
      {v1, v2, v3, out_valid, out_sat} <= '0;
      {a1, b1, a2, a3} <= '0;
      {out_x_re, out_x_im, out_y_re, out_y_im} <= '0;
    end else begin
      tw_addr_q <= tw_addr;
      if (accept) begin
        a1 <= {in_a_re, in_a_im};
        b1 <= {in_b_re, in_b_im};
      end
      if (adv) begin
        v1 <= in_valid;
        v2 <= v1;
        v3 <= v2;
        out_valid <= v3;
        a2 <= a1;
        a3 <= a2;
        out_x_re <= xr[DATA_W-1:0];
        out_x_im <= xi[DATA_W-1:0];
        out_y_re <= yr[DATA_W-1:0];
        out_y_im <= yi[DATA_W-1:0];
        out_sat <= xr[DATA_W] | xi[DATA_W] | yr[DATA_W] | yi[DATA_W];
      end
    end
endmodule

// File: tb/tb_fft_butterfly.sv
// tb_fft_butterfly: directed self-checking bench with a behavioural twiddle ROM
module tb_fft_butterfly;
  logic clk = 0;
  logic rst_n, in_valid, in_ready, out_valid, out_ready, out_sat;
  logic signed [7:0] in_a_re, in_a_im, in_b_re, in_b_im, tw_re, tw_im;
  logic signed [7:0] out_x_re, out_x_im, out_y_re, out_y_im;
  logic [2:0] in_tw_idx, tw_addr;
  int checks = 0;
  int errors = 0;
  logic signed [7:0] rom_re [8] = '{127, 91, 0, -91, -128, -91, 0, 91};
  logic signed [7:0] rom_im [8] = '{0, -91, -128, -91, 0, 91, 127, 91};
  int pr [8] = '{63, 45, 0, -46, -64, -46, 0, 45};
  int pim [8] = '{0, -46, -64, -46, 0, 45, 63, 45};

  always #5 clk = ~clk;

  always @(posedge clk) begin
    tw_re <= rom_re[tw_addr];
    tw_im <= rom_im[tw_addr];
  end

  fft_butterfly dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a_re(in_a_re), .in_a_im(in_a_im), .in_b_re(in_b_re), .in_b_im(in_b_im),
    .in_tw_idx(in_tw_idx), .tw_addr(tw_addr), .tw_re(tw_re), .tw_im(tw_im),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x_re(out_x_re), .out_x_im(out_x_im), .out_y_re(out_y_re), .out_y_im(out_y_im),
    .out_sat(out_sat)
  );

  function automatic int half(input int v);
`ifdef BFLY_ROUND_EN
    return (v + 1) >>> 1;
`else
    return v >>> 1;
`endif
  endfunction

  task automatic drive_pair(input int k);
    in_a_re = 8'(2 * k);
    in_a_im = 8'(2 * k);
    in_b_re = 8'sd64;
    in_b_im = 8'sd0;
    in_tw_idx = 3'(k);
  endtask

  task automatic check_stream(input string name, input int k);
    logic signed [7:0] exr, exi, eyr, eyi;
    exr = 8'(k + half(pr[k]));
    exi = 8'(k + half(pim[k]));
    eyr = 8'(k + half(-pr[k]));
    eyi = 8'(k + half(-pim[k]));
    checks++;
    if ({out_x_re, out_x_im, out_y_re, out_y_im, out_sat} !== {exr, exi, eyr, eyi, 1'b0}) begin
      errors++;
      $display("FAIL %s[%0d] got X=(%0d,%0d) Y=(%0d,%0d) sat=%b want X=(%0d,%0d) Y=(%0d,%0d) sat=0",
               name, k, out_x_re, out_x_im, out_y_re, out_y_im, out_sat, exr, exi, eyr, eyi);
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    in_valid = 0;
    out_ready = 1;
    drive_pair(0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 0 || out_sat !== 0) begin
      errors++;
      $display("FAIL reset_flags got valid=%b sat=%b want 0 0", out_valid, out_sat);
    end
    checks++;
    if ({out_x_re, out_x_im, out_y_re, out_y_im} !== 32'h0) begin
      errors++;
      $display("FAIL reset_data got %h want 0", {out_x_re, out_x_im, out_y_re, out_y_im});
    end
    checks++;
    if (tw_addr !== 3'd0 || in_ready !== 1) begin
      errors++;
      $display("FAIL reset_addr got tw_addr=%0d in_ready=%b want 0 1", tw_addr, in_ready);
    end
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_vectors();
    logic signed [7:0] va [3][4] = '{'{64, 0, 64, 0}, '{0, 0, 32, 0}, '{127, 0, 127, 127}};
    logic [2:0] vi [3] = '{0, 2, 1};
    logic sx [3] = '{0, 0, 1};
`ifdef BFLY_ROUND_EN
    logic signed [7:0] vx [3][4] = '{'{64, 0, 1, 0}, '{0, -16, 0, 16}, '{127, 0, -26, 0}};
`else
    logic signed [7:0] vx [3][4] = '{'{63, 0, 0, 0}, '{0, -16, 0, 16}, '{127, 0, -27, 0}};
`endif
    int lat;
    for (int v = 0; v < 3; v++) begin
      in_valid = 1;
      {in_a_re, in_a_im, in_b_re, in_b_im} = {va[v][0], va[v][1], va[v][2], va[v][3]};
      in_tw_idx = vi[v];
      #1;
      checks++;
      if (tw_addr !== vi[v] || in_ready !== 1) begin
        errors++;
        $display("FAIL vec%0d_addr got tw_addr=%0d in_ready=%b want %0d 1", v, tw_addr, in_ready, vi[v]);
      end
      @(posedge clk);
      #1;
      in_valid = 0;
      lat = 0;
      while (!out_valid && lat < 10) begin
        @(posedge clk);
        #1;
        lat++;
      end
      checks++;
      if (lat !== 3) begin
        errors++;
        $display("FAIL vec%0d_latency got %0d want 3", v, lat);
      end
      checks++;
      if ({out_x_re, out_x_im, out_y_re, out_y_im, out_sat} !== {vx[v][0], vx[v][1], vx[v][2], vx[v][3], sx[v]}) begin
        errors++;
        $display("FAIL vec%0d_data got X=(%0d,%0d) Y=(%0d,%0d) sat=%b want X=(%0d,%0d) Y=(%0d,%0d) sat=%b",
                 v, out_x_re, out_x_im, out_y_re, out_y_im, out_sat,
                 vx[v][0], vx[v][1], vx[v][2], vx[v][3], sx[v]);
      end
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 0) begin
        errors++;
        $display("FAIL vec%0d_pulse got out_valid=%b want 0", v, out_valid);
      end
    end
  endtask

  task automatic test_stall();
    int sent, got, cyc;
    logic froze, acc;
    logic [31:0] snap;
    sent = 0;
    got = 0;
    cyc = 0;
    froze = 0;
    snap = '0;
    while (got < 8 && cyc < 100) begin
      out_ready = !(cyc >= 4 && cyc < 9);
      in_valid = sent < 8;
      drive_pair(sent < 8 ? sent : 0);
      #1;
      if (froze) begin
        checks++;
        if ({out_x_re, out_x_im, out_y_re, out_y_im} !== snap) begin
          errors++;
          $display("FAIL stall_frozen got %h want %h", {out_x_re, out_x_im, out_y_re, out_y_im}, snap);
        end
      end
      froze = out_valid && !out_ready;
      if (froze) begin
        snap = {out_x_re, out_x_im, out_y_re, out_y_im};
        checks++;
        if (in_ready !== 0) begin
          errors++;
          $display("FAIL stall_in_ready got %b want 0", in_ready);
        end
      end
      if (out_valid && out_ready) begin
        check_stream("stall_data", got);
        got++;
      end
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) sent++;
      cyc++;
    end
    in_valid = 0;
    out_ready = 1;
    checks++;
    if (got !== 8 || sent !== 8) begin
      errors++;
      $display("FAIL stall_count got sent=%0d recv=%0d want 8 8", sent, got);
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 0) begin
      errors++;
      $display("FAIL stall_extra got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_reset_midstream();
    int stale;
    out_ready = 1;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1;
      drive_pair(k + 3);
      @(posedge clk);
      #1;
    end
    in_valid = 0;
    rst_n = 0;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 0 || tw_addr !== 3'd0) begin
      errors++;
      $display("FAIL midreset got out_valid=%b tw_addr=%0d want 0 0", out_valid, tw_addr);
    end
    rst_n = 1;
    stale = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (out_valid) stale++;
    end
    checks++;
    if (stale !== 0) begin
      errors++;
      $display("FAIL midreset_stale got %0d results want 0", stale);
    end
  endtask

  task automatic test_back_to_back();
    int sent, got, cyc, gaps, busy;
    sent = 0;
    got = 0;
    cyc = 0;
    gaps = 0;
    busy = 0;
    out_ready = 1;
    while (got < 6 && cyc < 40) begin
      in_valid = sent < 6;
      drive_pair(sent < 6 ? sent + 2 : 0);
      #1;
      if (!in_ready) busy++;
      if (out_valid) begin
        check_stream("b2b_data", got + 2);
        got++;
      end else if (got > 0) gaps++;
      @(posedge clk);
      #1;
      if (in_valid) sent++;
      cyc++;
    end
    in_valid = 0;
    checks++;
    if (got !== 6 || gaps !== 0 || busy !== 0) begin
      errors++;
      $display("FAIL b2b_flow got recv=%0d gaps=%0d stalls=%0d want 6 0 0", got, gaps, busy);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_stall();
    test_reset_midstream();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
